// File: rtl/d8m_sensor_emulator.sv
// D8M sensor-side pixel source: raw GRBG Bayer stream with FVAL/LVAL framing
// and selectable test patterns, registered on CCD_PIXCLK.
module d8m_sensor_emulator #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45,
    parameter int BAR_W    = 80
) (
    input  logic       CCD_PIXCLK,
    input  logic       RESET_SYS_N,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    input  logic [9:0] solid_value,
    output logic [9:0] CCD_DATA,
    output logic       CCD_FVAL,
    output logic       CCD_LVAL,
    output logic [15:0] frame_cnt,
    output logic       busy,
    output logic       frame_done
);
    localparam int          H_TOTAL    = H_ACTIVE + H_BLANK;
    localparam int          V_TOTAL    = V_ACTIVE + V_BLANK;
    localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
    localparam logic [15:0] H_START    = 16'(H_BLANK);
    localparam logic [15:0] V_ACT_LAST = 16'(V_ACTIVE - 1);
    localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
    localparam logic [15:0] BAR_LAST   = 16'(BAR_W - 1);
    localparam logic [9:0]  FULL       = 10'h3FF;

    typedef enum logic [1:0] {IDLE, ACTIVE, VBLANK} state_t;

    state_t      state_q, state_d;
    logic [15:0] h_q, h_d, v_q, v_d;
    logic [15:0] bar_pix_q, bar_pix_d;
    logic [2:0]  bar_q, bar_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [9:0]  solid_q, solid_d;
    logic [9:0]  data_q, data_d;
    logic        fval_q, fval_d, lval_q, lval_d;
    logic        line_end, frame_end, start;
    logic [9:0]  x;

    // GRBG site selection: even rows G/R, odd rows B/G; colour code bits are R,G,B.
    function automatic logic [9:0] bar_pixel(input logic [2:0] col, input logic xo, input logic yo);
        logic on;
        case ({yo, xo})
            2'b00, 2'b11: on = col[1];
            2'b01:        on = col[2];
            default:      on = col[0];
        endcase
        return on ? FULL : 10'h000;
    endfunction

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        v_d         = v_q;
        sel_d       = sel_q;
        solid_d     = solid_q;
        frame_cnt_d = frame_cnt_q;
        start       = 1'b0;
        frame_end   = 1'b0;
        line_end    = (h_q == H_LAST);
        if (line_end) begin
            h_d = '0;
            v_d = v_q + 16'd1;
        end else begin
            h_d = h_q + 16'd1;
        end
        case (state_q)
            IDLE: begin
                h_d = '0;
                v_d = '0;
                if (enable) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                if (line_end && v_q == V_ACT_LAST) state_d = VBLANK;
            end
            VBLANK: begin
                if (line_end && v_q == V_LAST) begin
                    frame_end   = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    v_d         = '0;
                    if (enable) begin
                        state_d = ACTIVE;
                        start   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Pattern controls are frozen for the whole frame.
        if (start) begin
            sel_d   = pattern_sel;
            solid_d = solid_value;
        end
    end

    always_comb begin
        fval_d    = (state_q == ACTIVE);
        lval_d    = fval_d && (h_q >= H_START);
        x         = 10'(h_q - H_START);
        bar_d     = '0;
        bar_pix_d = '0;
        // Bar index tracks x incrementally so no divider is needed.
        if (lval_d) begin
            if (bar_pix_q == BAR_LAST) begin
                bar_d = bar_q + 3'd1;
            end else begin
                bar_d     = bar_q;
                bar_pix_d = bar_pix_q + 16'd1;
            end
        end
        data_d = '0;
        if (lval_d) begin
            case (sel_q)
                2'd0:    data_d = bar_pixel(~bar_q, x[0], v_q[0]);
                2'd1:    data_d = x;
                2'd2:    data_d = solid_q;
                default: data_d = (x[4] ^ v_q[4] ^ frame_cnt_q[0]) ? FULL : 10'h000;
            endcase
        end
    end

    always_ff @(posedge CCD_PIXCLK or negedge RESET_SYS_N) begin
        if (!RESET_SYS_N) begin
            state_q     <= IDLE;
            h_q         <= '0;
            v_q         <= '0;
            bar_q       <= '0;
            bar_pix_q   <= '0;
            frame_cnt_q <= '0;
            sel_q       <= '0;
            solid_q     <= '0;
            data_q      <= '0;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            bar_q       <= bar_d;
            bar_pix_q   <= bar_pix_d;
            frame_cnt_q <= frame_cnt_d;
            sel_q       <= sel_d;
            solid_q     <= solid_d;
            data_q      <= data_d;
            fval_q      <= fval_d;
            lval_q      <= lval_d;
        end
    end

    assign CCD_DATA   = data_q;
    assign CCD_FVAL   = fval_q;
    assign CCD_LVAL   = lval_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_end;
endmodule

// File: tb/tb_d8m_sensor_emulator.sv
// Bench for d8m_sensor_emulator with small frame geometry; every cycle is
// compared against a frame-timeline model built from position arithmetic.
module tb_d8m_sensor_emulator;
    localparam int HA = 16, HB = 4, VA = 4, VB = 2, BW = 2;
    localparam int HT = HA + HB;
    localparam int VT = VA + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [9:0]  solid_value;
    logic [9:0]  ccd_data;
    logic        ccd_fval, ccd_lval, busy, frame_done;
    logic [15:0] frame_cnt;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int sel_a [0:7];
    int sol_a [0:7];

    d8m_sensor_emulator #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .BAR_W(BW)) dut (
        .CCD_PIXCLK (clk),
        .RESET_SYS_N(rst_n),
        .enable     (enable),
        .pattern_sel(pattern_sel),
        .solid_value(solid_value),
        .CCD_DATA   (ccd_data),
        .CCD_FVAL   (ccd_fval),
        .CCD_LVAL   (ccd_lval),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Expected {fval, lval, data[9:0]} for a frame position (0..FT-1).
    function automatic int exp_px(input int pos, input int sel, input int solid, input int fc0);
        int line, col, x, y, b, c, bit_on;
        line = pos / HT;
        col  = pos % HT;
        if (line >= VA) return 0;
        if (col < HB) return 1 << 11;
        x = col - HB;
        y = line;
        case (sel)
            0: begin
                b = x / BW;
                c = 7 - b;
                if (y % 2 == 0) bit_on = (x % 2 == 0) ? (c >> 1) & 1 : (c >> 2) & 1;
                else            bit_on = (x % 2 == 0) ? c & 1 : (c >> 1) & 1;
                return (3 << 10) | (bit_on ? 1023 : 0);
            end
            1:       return (3 << 10) | (x % 1024);
            2:       return (3 << 10) | solid;
            default: return (3 << 10) | ((((x >> 4) ^ (y >> 4) ^ fc0) & 1) ? 1023 : 0);
        endcase
    endfunction

    // Starts streaming from IDLE at the current negedge; enable drops at drop_m.
    task automatic run_stream(input int nf, input int ncyc, input int drop_m, input int base);
        int q, p, e;
        bit run;
        pattern_sel = 2'(sel_a[0]);
        solid_value = 10'(sol_a[0]);
        enable      = 1'b1;
        for (int m = 1; m <= ncyc; m++) begin
            @(negedge clk);
            q   = m - 1;
            p   = m - 2;
            run = (q < nf * FT);
            chk("busy", 32'(busy), run ? 1 : 0);
            chk("frame_done", 32'(frame_done), (run && (q % FT == FT - 1)) ? 1 : 0);
            chk("frame_cnt", 32'(frame_cnt), (base + (run ? q / FT : nf)) % 65536);
            if (p >= 0 && p < nf * FT)
                e = exp_px(p % FT, sel_a[p / FT], sol_a[p / FT], (base + p / FT) & 1);
            else
                e = 0;
            chk("pixel", 32'({ccd_fval, ccd_lval, ccd_data}), e);
            if (m % FT == 0 && m / FT < nf) begin
                pattern_sel = 2'(sel_a[m / FT]);
                solid_value = 10'(sol_a[m / FT]);
            end
            if (m % FT == FT / 2) begin
                pattern_sel = (sel_a[q / FT] == 2) ? 2'd1 : 2'($urandom_range(0, 3));
                solid_value = 10'($urandom);
            end
            if (m == drop_m) enable = 1'b0;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        solid_value = 10'd0;
        #3;
        chk("reset_out", 32'({busy, frame_done, ccd_fval, ccd_lval, ccd_data}), 0);
        chk("reset_cnt", 32'(frame_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_out", 32'({busy, frame_done, ccd_fval, ccd_lval, ccd_data}), 0);
        end

        // Ramp, bars, checker, random, then solid with enable dropped on line 1.
        sel_a[0] = 1; sol_a[0] = int'($urandom_range(0, 1023));
        sel_a[1] = 0; sol_a[1] = int'($urandom_range(0, 1023));
        sel_a[2] = 3; sol_a[2] = int'($urandom_range(0, 1023));
        sel_a[3] = int'($urandom_range(0, 3)); sol_a[3] = int'($urandom_range(0, 1023));
        sel_a[4] = 2; sol_a[4] = int'($urandom_range(0, 1023));
        run_stream(5, 5 * FT + 10, 4 * FT + HT + 5, 0);

        // Reset asserted in the middle of a line.
        enable = 1'b1;
        repeat (50) @(negedge clk);
        chk("pre_reset_lval", 32'({ccd_fval, ccd_lval}), 3);
        chk("pre_reset_cnt", 32'(frame_cnt), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", 32'({ccd_fval, ccd_lval, ccd_data}), 0);
        chk("async_reset_cnt", 32'(frame_cnt), 0);
        chk("async_reset_busy", 32'(busy), 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sel_a[0] = 3; sol_a[0] = 0;
        run_stream(1, FT + 10, 5, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
